// File: rtl/anti_jitter_array_if.sv
// Signal bundle between board-level inputs and the debouncer array.
// The master side drives the raw inputs and enable; the slave side returns clean levels and events.
interface anti_jitter_array_if #(
   parameter int CHANNELS = 8
) ();
   logic                ce;
   logic [CHANNELS-1:0] I;
   logic [CHANNELS-1:0] O;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] held;
   logic                any_event;

   modport master (
      output ce, I,
      input  O, rise, fall, held, any_event
   );

   modport slave (
      input  ce, I,
      output O, rise, fall, held, any_event
   );
endinterface

// File: rtl/anti_jitter_array.sv
// Multi-channel debouncer: synchroniser, saturating integrator with hysteresis,
// clean level with rise/fall pulses, long-hold flag and a global event strobe.
module anti_jitter_array #(
   parameter int                  CHANNELS    = 8,
   parameter int                  WIDTH       = 20,
   parameter logic [CHANNELS-1:0] INIT        = {CHANNELS{1'b0}},
   parameter int                  SYNC_STAGES = 2,
   parameter int                  HOLD_WIDTH  = 24
) (
   input logic               clk,
   input logic               rst,
   anti_jitter_array_if.slave bus
);

   if (WIDTH < 1 || HOLD_WIDTH < 1 || SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_param_check
      $error("anti_jitter_array: illegal WIDTH, HOLD_WIDTH or SYNC_STAGES");
   end

   localparam logic [WIDTH-1:0]      CNT_MAX   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]      CNT_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]      CNT_ONE   = WIDTH'(1'b1);
   localparam logic [HOLD_WIDTH-1:0] HOLD_MAX  = {HOLD_WIDTH{1'b1}};
   localparam logic [HOLD_WIDTH-1:0] HOLD_ZERO = {HOLD_WIDTH{1'b0}};
   localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1'b1);

   logic [CHANNELS-1:0]   s_s;
   logic [WIDTH-1:0]      cnt_r       [CHANNELS];
   logic [WIDTH-1:0]      cnt_next_s  [CHANNELS];
   logic [HOLD_WIDTH-1:0] hold_r      [CHANNELS];
   logic [HOLD_WIDTH-1:0] hold_next_s [CHANNELS];
   logic [CHANNELS-1:0]   o_r, o_next_s;
   logic [CHANNELS-1:0]   held_r, held_next_s;
   logic [CHANNELS-1:0]   rise_r, rise_next_s;
   logic [CHANNELS-1:0]   fall_r, fall_next_s;
   logic                  any_event_r;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign s_s = bus.I;
   end else begin : g_sync
      logic [CHANNELS-1:0] sync_r [SYNC_STAGES];

      // Synchroniser shift chain; runs regardless of ce so it never holds stale samples.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
               sync_r[j] <= INIT;
            end
         end else begin
            sync_r[0] <= bus.I;
            for (int j = 1; j < SYNC_STAGES; j++) begin
               sync_r[j] <= sync_r[j-1];
            end
         end
      end

      assign s_s = sync_r[SYNC_STAGES-1];
   end

   // Next-state for integrators, levels, hold counters and event pulses.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_next_s[i] = cnt_r[i];
         o_next_s[i]   = o_r[i];
         if (s_s[i]) begin
            if (cnt_r[i] == CNT_MAX) begin
               o_next_s[i] = 1'b1;
            end else begin
               cnt_next_s[i] = cnt_r[i] + CNT_ONE;
            end
         end else begin
            if (cnt_r[i] != CNT_ZERO) begin
               cnt_next_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
               o_next_s[i] = 1'b0;
            end
         end

         // The hold time counts cycles already spent high, so the rising edge itself does not count.
         if (o_r[i] && o_next_s[i]) begin
            if (hold_r[i] == HOLD_MAX) begin
               hold_next_s[i] = hold_r[i];
            end else begin
               hold_next_s[i] = hold_r[i] + HOLD_ONE;
            end
         end else begin
            hold_next_s[i] = HOLD_ZERO;
         end
         held_next_s[i] = o_next_s[i] && (hold_next_s[i] == HOLD_MAX);
      end
      rise_next_s = {CHANNELS{bus.ce}} & ~o_r &  o_next_s;
      fall_next_s = {CHANNELS{bus.ce}} &  o_r & ~o_next_s;
   end

   // State registers; ce freezes integrators and hold tracking, pulses always refresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_r[i]  <= INIT[i] ? CNT_MAX : CNT_ZERO;
            hold_r[i] <= HOLD_ZERO;
         end
         o_r         <= INIT;
         held_r      <= {CHANNELS{1'b0}};
         rise_r      <= {CHANNELS{1'b0}};
         fall_r      <= {CHANNELS{1'b0}};
         any_event_r <= 1'b0;
      end else begin
         if (bus.ce) begin
            cnt_r  <= cnt_next_s;
            hold_r <= hold_next_s;
            o_r    <= o_next_s;
            held_r <= held_next_s;
         end
         rise_r      <= rise_next_s;
         fall_r      <= fall_next_s;
         any_event_r <= |(rise_next_s | fall_next_s);
      end
   end

   assign bus.O         = o_r;
   assign bus.rise      = rise_r;
   assign bus.fall      = fall_r;
   assign bus.held      = held_r;
   assign bus.any_event = any_event_r;

endmodule

// File: tb/tb_anti_jitter_array.sv
// Directed bench for anti_jitter_array with 4 channels, 4-bit integrators and 5-bit hold counters.
module tb_anti_jitter_array;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [3:0] acc_s;
   logic       acc_o_s;

   anti_jitter_array_if #(.CHANNELS(4)) bus ();

   anti_jitter_array #(
      .CHANNELS   (4),
      .WIDTH      (4),
      .INIT       (4'b0100),
      .SYNC_STAGES(2),
      .HOLD_WIDTH (5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_rise"}, bus.rise, 4'b0000);
      check({tag, "_fall"}, bus.fall, 4'b0000);
      check({tag, "_held"}, bus.held, 4'b0000);
      check({tag, "_any"}, 4'(bus.any_event), 4'b0000);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset with all inputs high
      rst    = 1'b1;
      bus.ce = 1'b1;
      bus.I  = 4'b1111;
      tick(3);
      check("rst_O", bus.O, 4'b0100);
      check_quiet("rst");
      rst   = 1'b0;
      bus.I = 4'b0100;
      tick(1);
      check("post_rst_O", bus.O, 4'b0100);
      check_quiet("post_rst");
      acc_s = 4'b0000;
      for (int k = 0; k < 29; k++) begin
         tick(1);
         acc_s = acc_s | bus.rise | bus.fall;
      end
      check("init_no_events", acc_s, 4'b0000);
      check("init_held2_early", 4'(bus.held[2]), 4'b0000);
      tick(1);
      check("init_held2", bus.held, 4'b0100);

      // Clean press on ch0: O after edge 17, held after edge 48
      bus.I = 4'b0101;
      tick(17);
      check("press_O_early", bus.O, 4'b0100);
      check("press_rise_early", bus.rise, 4'b0000);
      tick(1);
      check("press_O", bus.O, 4'b0101);
      check("press_rise", bus.rise, 4'b0001);
      check("press_any", 4'(bus.any_event), 4'b0001);
      tick(1);
      check("press_rise_gone", bus.rise, 4'b0000);
      check("press_any_gone", 4'(bus.any_event), 4'b0000);
      tick(29);
      check("hold_early", 4'(bus.held[0]), 4'b0000);
      tick(1);
      check("hold_set", 4'(bus.held[0]), 4'b0001);

      // Release ch0 from held state
      bus.I = 4'b0100;
      tick(17);
      check("rel_O_early", 4'(bus.O[0]), 4'b0001);
      check("rel_held_early", 4'(bus.held[0]), 4'b0001);
      tick(1);
      check("rel_O", bus.O, 4'b0100);
      check("rel_held", 4'(bus.held[0]), 4'b0000);
      check("rel_fall", bus.fall, 4'b0001);
      check("rel_any", 4'(bus.any_event), 4'b0001);
      tick(1);
      check("rel_fall_gone", bus.fall, 4'b0000);

      // Bounce on ch1, toggling every 3 cycles
      acc_s   = 4'b0000;
      acc_o_s = 1'b0;
      for (int c = 0; c < 100; c++) begin
         bus.I[1] = ((c / 3) % 2 == 0) ? 1'b1 : 1'b0;
         tick(1);
         acc_s   = acc_s | bus.rise | bus.fall;
         acc_o_s = acc_o_s | bus.O[1];
      end
      check("bounce_O", 4'(acc_o_s), 4'b0000);
      check("bounce_events", acc_s, 4'b0000);
      bus.I[1] = 1'b1;
      tick(15);
      check("bounce_settle_early", 4'(bus.O[1]), 4'b0000);
      tick(1);
      check("bounce_settle_O", 4'(bus.O[1]), 4'b0001);
      check("bounce_settle_rise", bus.rise, 4'b0010);

      // ch3 press with ce dropped for 10 cycles mid-count
      bus.I[3] = 1'b1;
      tick(8);
      bus.ce = 1'b0;
      acc_s  = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         acc_s = acc_s | bus.rise | bus.fall | 4'(bus.any_event);
      end
      check("ce_no_pulses", acc_s, 4'b0000);
      check("ce_O_frozen", 4'(bus.O[3]), 4'b0000);
      bus.ce = 1'b1;
      tick(9);
      check("ce_O_early", 4'(bus.O[3]), 4'b0000);
      tick(1);
      check("ce_O", bus.O, 4'b1110);
      check("ce_rise", bus.rise, 4'b1000);

      // Simultaneous press on ch0 and release on ch2
      tick(2);
      bus.I = 4'b1011;
      tick(17);
      check("sim_O_early", bus.O, 4'b1110);
      tick(1);
      check("sim_O", bus.O, 4'b1011);
      check("sim_rise", bus.rise, 4'b0001);
      check("sim_fall", bus.fall, 4'b0100);
      check("sim_any", 4'(bus.any_event), 4'b0001);
      tick(1);
      check("sim_any_single", 4'(bus.any_event), 4'b0000);
      check("sim_rise_gone", bus.rise, 4'b0000);

      // Repeat in the other direction, resetting at cnt=8
      bus.I = 4'b1110;
      tick(10);
      rst = 1'b1;
      tick(1);
      check("mid_rst_O", bus.O, 4'b0100);
      check_quiet("mid_rst");
      rst = 1'b0;
      tick(17);
      check("mid_rst_O_early", bus.O, 4'b0100);
      check("mid_rst_rise_early", bus.rise, 4'b0000);
      tick(1);
      check("mid_rst_O_after", bus.O, 4'b1110);
      check("mid_rst_rise_after", bus.rise, 4'b1010);
      check("mid_rst_any_after", 4'(bus.any_event), 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
